systolic_drain_ctrl: RTL and testbench

Read-side controller for the systolic array's output buffer. After the array has finished writing skewed result words (column j of row r stored at address r+j), this block reads addresses sequentially and de-skews the columns with a triangular delay network. It emits one aligned result row per beat on a valid/ready stream towards the post-processing stage (GELU/softmax/requant).

---
 rtl/systolic_drain_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_systolic_drain_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain_ctrl.sv
// Drain controller for the systolic output buffer: sequential reads, column de-skew, valid/ready row stream.
// Optional macro SYS_DRAIN_PERF_EN adds the stall_cycles performance counter port.
module systolic_drain_ctrl #(
    parameter int DATAWIDTH_output = 32,
    parameter int N_SIZE           = 32,
    parameter int ROWS             = 512,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              num_rows,
    output logic                               busy,
    output logic                               done,
    output logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic [DATAWIDTH_output*N_SIZE-1:0] rd_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATAWIDTH_output*N_SIZE-1:0] out_data,
    output logic                               out_last,
    output logic [ADDR_WIDTH-1:0]              out_row_idx
`ifdef SYS_DRAIN_PERF_EN
    ,
    output logic [31:0]                        stall_cycles
`endif
);

    localparam int DW    = DATAWIDTH_output;
    localparam int ROW_W = DATAWIDTH_output * N_SIZE;
    localparam logic [ADDR_WIDTH-1:0] PRIME_READS = ADDR_WIDTH'(N_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] TAIL_READS  = ADDR_WIDTH'(N_SIZE - 2);
    localparam logic [ADDR_WIDTH:0]   ROWS_MAX    = (ADDR_WIDTH + 1)'(ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [ADDR_WIDTH-1:0] n_start;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  vld_p0;
    logic                  done_q;

    logic                  vld_p1;
    logic [ROW_W-1:0]      data_p1;
    logic                  last_p1;
    logic [ADDR_WIDTH-1:0] idx_p1;

    logic [ROW_W-1:0]      aligned_p0;
    logic [ADDR_WIDTH-1:0] row_of_ptr;

    logic                  advance;
    logic                  start_acc;
    logic                  issue;
    logic                  last_issue;
    logic                  consume;
    logic                  emit;
    logic                  last_accept;

    always_comb begin
        n_start = num_rows;
        if ({1'b0, num_rows} > ROWS_MAX) begin
            n_start = ROWS_MAX[ADDR_WIDTH-1:0];
        end
    end

    // The whole read/de-skew/output pipeline stalls as one unit on downstream backpressure.
    assign advance     = !vld_p1 || out_ready;
    assign start_acc   = (state_q == IDLE) && start;
    assign issue       = (state_q == RUN) && advance;
    assign consume     = vld_p0 && advance;
    assign row_of_ptr  = ptr_q - PRIME_READS;
    assign emit        = consume && (ptr_q >= PRIME_READS);
    assign last_accept = (state_q == DRAIN) && vld_p1 && out_ready && last_p1;

    // First issue of a drain is address 0; a stalled cycle re-presents the held address.
    always_comb begin
        rd_addr = ptr_q;
        if (issue) begin
            rd_addr = vld_p0 ? (ptr_q + ADDR_WIDTH'(1)) : '0;
        end
    end

    assign last_issue = issue && (rd_addr == last_addr_q);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && (n_start != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Stage p0: read pointer and pending-word flag for the word on rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q         <= '0;
            last_addr_q <= '0;
            ptr_q       <= '0;
            vld_p0      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (start_acc && (n_start == '0)) || last_accept;
            if (start_acc) begin
                n_q         <= n_start;
                last_addr_q <= n_start + TAIL_READS;
                ptr_q       <= '0;
                vld_p0      <= 1'b0;
            end else if (last_accept) begin
                ptr_q  <= '0;
                vld_p0 <= 1'b0;
            end else if (issue) begin
                ptr_q  <= rd_addr;
                vld_p0 <= 1'b1;
            end else if (consume) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    // Triangular delay network: lane j is delayed by N_SIZE-1-j consumed words.
    for (genvar j = 0; j < N_SIZE; j++) begin : g_lane
        localparam int DEPTH = N_SIZE - 1 - j;
        if (DEPTH == 0) begin : g_direct
            assign aligned_p0[j*DW +: DW] = rd_data[j*DW +: DW];
        end else begin : g_delay
            logic [DW-1:0] dly_p0 [DEPTH];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        dly_p0[k] <= '0;
                    end
                end else if (consume) begin
                    dly_p0[0] <= rd_data[j*DW +: DW];
                    for (int k = 1; k < DEPTH; k++) begin
                        dly_p0[k] <= dly_p0[k-1];
                    end
                end
            end
            assign aligned_p0[j*DW +: DW] = dly_p0[DEPTH-1];
        end
    end

    // Stage p1: output register, held while the downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            idx_p1  <= '0;
        end else if (advance) begin
            if (emit) begin
                vld_p1  <= 1'b1;
                data_p1 <= aligned_p0;
                idx_p1  <= row_of_ptr;
                last_p1 <= (row_of_ptr == (n_q - ADDR_WIDTH'(1)));
            end else begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign out_data    = data_p1;
    assign out_last    = last_p1;
    assign out_row_idx = idx_p1;
    assign done        = done_q;

`ifdef SYS_DRAIN_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if (vld_p1 && !out_ready) begin
            stall_cnt_q <= sat_inc32(stall_cnt_q);
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Self-checking bench for systolic_drain_ctrl with a skewed-buffer model and a row-level reference.
module tb_systolic_drain_ctrl;

    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int ROWS = 8;
    localparam int AW   = 4;
    localparam int W    = DW * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_rows = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [AW-1:0] out_row_idx;
`ifdef SYS_DRAIN_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    systolic_drain_ctrl #(
        .DATAWIDTH_output(DW),
        .N_SIZE(N),
        .ROWS(ROWS),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_rows(num_rows),
        .busy(busy),
        .done(done),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .out_row_idx(out_row_idx)
`ifdef SYS_DRAIN_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cur_n = 0;

    // Skewed buffer: column j of row r lives at address r+j, one-cycle read latency.
    function automatic logic [W-1:0] buf_word(input int a, input int n);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            if ((a - j) >= 0 && (a - j) < n) v[j*DW +: DW] = 8'(16 * (a - j) + j);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] exp_row(input int r);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = 8'(16 * r + j);
        return v;
    endfunction

    always @(posedge clk) rd_data <= buf_word(int'(rd_addr), cur_n);

    logic [W-1:0]  beat_data [$];
    logic [AW-1:0] beat_idx [$];
    logic          beat_last [$];
    int            beat_cyc [$];
    int done_cyc, done_cnt, stab_err, rep_err, valid_seen, busy1, busy_at_done, timeout;

    // Drives one drain and records what the DUT emitted; the test tasks judge the record.
    task automatic run_drain(input int nr, input int pct, input int hold, input int restart_at,
                             input int abort_after, input int max_cyc);
        logic [W-1:0] pd;
        logic [AW-1:0] pidx, paddr;
        logic pl, pv, pr, pbusy;
        int hold_left;
        hold_left = hold;
        beat_data.delete(); beat_idx.delete(); beat_last.delete(); beat_cyc.delete();
        done_cyc = -1; done_cnt = 0; stab_err = 0; rep_err = 0;
        valid_seen = 0; busy1 = 0; busy_at_done = -1; timeout = 0;
        @(posedge clk); #1;
        cur_n = (nr > ROWS) ? ROWS : nr;
        start = 1'b1; num_rows = AW'(nr); out_ready = 1'b1;
        #1;
        pv = out_valid; pr = out_ready; pd = out_data; pidx = out_row_idx; pl = out_last;
        paddr = rd_addr; pbusy = busy;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            start = (c == restart_at);
            if (c == restart_at) num_rows = AW'(1);
            if (out_valid && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = ($urandom_range(99) < pct);
            end
            #1;
            if (c == 1) busy1 = busy;
            if (out_valid) valid_seen++;
            if (pv && !pr && (!out_valid || out_data !== pd || out_row_idx !== pidx || out_last !== pl))
                stab_err++;
            if (out_valid && !out_ready && pbusy && rd_addr !== paddr) rep_err++;
            if (out_valid && out_ready) begin
                beat_data.push_back(out_data);
                beat_idx.push_back(out_row_idx);
                beat_last.push_back(out_last);
                beat_cyc.push_back(c);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    busy_at_done = busy;
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pidx = out_row_idx; pl = out_last;
            paddr = rd_addr; pbusy = busy;
            if (abort_after >= 0 && beat_data.size() == abort_after) return;
            if (done_cyc >= 0 && c >= done_cyc + 2) return;
        end
        timeout = 1;
    endtask

    task automatic check_rows(input string tag, input int n_exp);
        n_cmp++;
        if (beat_data.size() != n_exp) begin
            n_err++;
            $display("FAIL %s beat_count got %0d want %0d", tag, beat_data.size(), n_exp);
        end
        for (int i = 0; i < beat_data.size() && i < n_exp; i++) begin
            n_cmp++;
            if (beat_data[i] !== exp_row(i) || beat_idx[i] !== AW'(i) || beat_last[i] !== (i == n_exp - 1)) begin
                n_err++;
                $display("FAIL %s row%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         tag, i, beat_data[i], beat_idx[i], beat_last[i], exp_row(i), i, (i == n_exp - 1));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got busy=%b done=%b valid=%b last=%b want 0000", busy, done, out_valid, out_last);
        end
        n_cmp++;
        if (out_data !== '0 || out_row_idx !== '0 || rd_addr !== '0) begin
            n_err++;
            $display("FAIL reset_data got data=%h idx=%0d addr=%0d want 0 0 0", out_data, out_row_idx, rd_addr);
        end
`ifdef SYS_DRAIN_PERF_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stall got %0d want 0", stall_cycles);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || rd_addr !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset got busy=%b valid=%b addr=%0d want 0 0 0", busy, out_valid, rd_addr);
        end
    endtask

    task automatic test_basic();
        run_drain(8, 100, 0, -1, -1, 40);
        n_cmp++;
        if (timeout != 0) begin n_err++; $display("FAIL basic_timeout got %0d want 0", timeout); end
        check_rows("basic", 8);
        for (int i = 0; i < beat_cyc.size(); i++) begin
            n_cmp++;
            if (beat_cyc[i] != 6 + i) begin
                n_err++;
                $display("FAIL basic_beat_cycle row%0d got %0d want %0d", i, beat_cyc[i], 6 + i);
            end
        end
        n_cmp++;
        if (done_cyc != 14 || done_cnt != 1) begin
            n_err++;
            $display("FAIL basic_done got cycle=%0d count=%0d want 14 1", done_cyc, done_cnt);
        end
        n_cmp++;
        if (busy1 != 1 || busy_at_done != 0) begin
            n_err++;
            $display("FAIL basic_busy got at1=%0d at_done=%0d want 1 0", busy1, busy_at_done);
        end
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 3; it++) begin
            run_drain(8, 50, 0, -1, -1, 200);
            n_cmp++;
            if (timeout != 0) begin n_err++; $display("FAIL bp_timeout got %0d want 0", timeout); end
            check_rows("backpressure", 8);
            n_cmp++;
            if (stab_err != 0 || rep_err != 0) begin
                n_err++;
                $display("FAIL bp_stall_hold got data_changes=%0d addr_changes=%0d want 0 0", stab_err, rep_err);
            end
            n_cmp++;
            if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
        end
    endtask

    task automatic test_clamp_zero();
        run_drain(12, 100, 0, -1, -1, 40);
        check_rows("clamp", 8);
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL clamp_done got %0d want 1", done_cnt); end
        run_drain(0, 100, 0, -1, -1, 10);
        n_cmp++;
        if (done_cyc != 1 || done_cnt != 1 || valid_seen != 0 || beat_data.size() != 0) begin
            n_err++;
            $display("FAIL zero_rows got done_cyc=%0d done_cnt=%0d valid=%0d beats=%0d want 1 1 0 0",
                     done_cyc, done_cnt, valid_seen, beat_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        run_drain(8, 100, 0, -1, 3, 40);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || out_row_idx !== '0 || rd_addr !== '0) begin
            n_err++;
            $display("FAIL mid_reset got busy=%b done=%b valid=%b last=%b data=%h idx=%0d addr=%0d want all 0",
                     busy, done, out_valid, out_last, out_data, out_row_idx, rd_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done) done_seen++;
        n_cmp++;
        if (done_seen != 0) begin n_err++; $display("FAIL mid_reset_done got %0d want 0", done_seen); end
        run_drain(2, 100, 0, -1, -1, 30);
        check_rows("after_reset", 2);
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL after_reset_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_busy();
        run_drain(8, 100, 0, 3, -1, 40);
        check_rows("start_busy", 8);
        n_cmp++;
        if (done_cyc != 14 || done_cnt != 1) begin
            n_err++;
            $display("FAIL start_busy_done got cycle=%0d count=%0d want 14 1", done_cyc, done_cnt);
        end
    endtask

`ifdef SYS_DRAIN_PERF_EN
    task automatic test_perf();
        run_drain(3, 100, 5, -1, -1, 40);
        check_rows("perf", 3);
        n_cmp++;
        if (stall_cycles !== 32'd5) begin
            n_err++;
            $display("FAIL perf_stall got %0d want 5", stall_cycles);
        end
        @(posedge clk); #1;
        start = 1'b1; num_rows = '0; cur_n = 0;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL perf_clear got %0d want 0", stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clamp_zero();
        test_reset_mid();
        test_start_busy();
`ifdef SYS_DRAIN_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
